// File: rtl/spi_prot_tx_pkg.sv
// Shared definitions for the SPI master transmitter.
//   state_t      : FSM state encoding (legacy-compatible localparam constants)
//   LEN8 / LEN16 : supported frame lengths in bits
//   last_bit()   : index of the final bit for the selected frame length
package spi_prot_tx_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StIdle  = 3'd0;
  localparam state_t StFront = 3'd1;
  localparam state_t StLow   = 3'd2;
  localparam state_t StHigh  = 3'd3;
  localparam state_t StBack  = 3'd4;

  localparam int unsigned LEN8  = 8;
  localparam int unsigned LEN16 = 16;

  // bit_cnt value seen on the final HIGH phase of a frame.
  function automatic logic [4:0] last_bit(input logic len8);
    return len8 ? 5'(LEN8 - 1) : 5'(LEN16 - 1);
  endfunction

endpackage

// File: rtl/spi_prot_tx_half_timer.sv
// SCLK half-period timer.
//   clk_i   : system clock
//   rst_i   : synchronous reset, active-high
//   run_i   : timer counts while high, held at zero otherwise
//   start_i : restart at zero on the next cycle (phase entry)
//   tick_o  : one-cycle pulse on the last cycle of a phase (count SCLK_HALF-1)
module spi_prot_tx_half_timer #(
  parameter int unsigned SCLK_HALF = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  input  logic start_i,
  output logic tick_o
);

  localparam int unsigned CntW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam logic [CntW-1:0] TickVal = CntW'(SCLK_HALF - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick_o = run_i && (cnt_q == TickVal);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!run_i || start_i) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_prot_tx.sv
// SPI master transmitter: one 8- or 16-bit frame, MSB first, per accepted write.
//   clk, rst          : system clock, synchronous active-high reset
//   wrt               : start a frame (only while busy is low)
//   tx_data[15:0]     : frame data; 8-bit frames send tx_data[7:0]
//   len8              : 1 = 8-bit frame, 0 = 16-bit frame
//   edg               : 1 = receiver samples on SCLK rise, 0 = on SCLK fall
//   SS_n, SCLK, MOSI  : SPI bus outputs, all registered; SCLK idles high
//   busy              : frame in progress
//   done              : one-cycle pulse after the frame ends
// Frame: FRONT, then N x (LOW, HIGH), then BACK; every phase lasts SCLK_HALF cycles.
module spi_prot_tx
  import spi_prot_tx_pkg::*;
#(
  parameter int unsigned SCLK_HALF = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wrt,
  input  logic [15:0] tx_data,
  input  logic        len8,
  input  logic        edg,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  output logic        busy,
  output logic        done
);

  state_t      state_q, state_d;
  logic [15:0] shreg_q, shreg_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic        len8_q, len8_d;
  logic        edg_q, edg_d;
  logic        ss_n_q, ss_n_d;
  logic        sclk_q, sclk_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        tick;
  logic        phase_adv;
  logic        run;
  logic [4:0]  last;
  logic [15:0] shifted;

  assign run     = (state_q != StIdle);
  assign last    = last_bit(len8_q);
  assign shifted = {shreg_q[14:0], 1'b1};

  spi_prot_tx_half_timer #(
    .SCLK_HALF (SCLK_HALF)
  ) u_half_timer (
    .clk_i   (clk),
    .rst_i   (rst),
    .run_i   (run),
    .start_i (phase_adv),
    .tick_o  (tick)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    len8_d    = len8_q;
    edg_d     = edg_q;
    ss_n_d    = ss_n_q;
    sclk_d    = sclk_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    phase_adv = 1'b0;

    case (state_q)
      StIdle: begin
        if (wrt) begin
          phase_adv = 1'b1;
          state_d   = StFront;
          // 8-bit data sits in the top byte so MOSI is always shreg[15].
          shreg_d   = len8 ? {tx_data[7:0], 8'hFF} : tx_data;
          bit_cnt_d = '0;
          len8_d    = len8;
          edg_d     = edg;
          ss_n_d    = 1'b0;
          sclk_d    = 1'b1;
          busy_d    = 1'b1;
        end
      end
      StFront: begin
        if (tick) begin
          phase_adv = 1'b1;
          state_d   = StLow;
          sclk_d    = 1'b0;
        end
      end
      StLow: begin
        if (tick) begin
          phase_adv = 1'b1;
          state_d   = StHigh;
          sclk_d    = 1'b1;
          // Fall-sampling receiver: advance data on every rise except the last.
          if (!edg_q && (bit_cnt_q != last)) begin
            shreg_d = shifted;
          end
        end
      end
      StHigh: begin
        if (tick) begin
          phase_adv = 1'b1;
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == last) begin
            state_d = StBack;
          end else begin
            state_d = StLow;
            sclk_d  = 1'b0;
            // Rise-sampling receiver: advance data on every fall after the first.
            if (edg_q) begin
              shreg_d = shifted;
            end
          end
        end
      end
      StBack: begin
        if (tick) begin
          phase_adv = 1'b1;
          state_d   = StIdle;
          shreg_d   = '1;
          ss_n_d    = 1'b1;
          busy_d    = 1'b0;
          done_d    = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        shreg_d = '1;
        ss_n_d  = 1'b1;
        sclk_d  = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      shreg_q   <= '1;
      bit_cnt_q <= '0;
      len8_q    <= 1'b0;
      edg_q     <= 1'b0;
      ss_n_q    <= 1'b1;
      sclk_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      len8_q    <= len8_d;
      edg_q     <= edg_d;
      ss_n_q    <= ss_n_d;
      sclk_q    <= sclk_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign SS_n = ss_n_q;
  assign SCLK = sclk_q;
  assign MOSI = shreg_q[15];
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_spi_prot_tx.sv
// Self-checking bench for spi_prot_tx (SCLK_HALF = 4). A bus monitor acts as the
// receiver: it samples MOSI on the edg-selected SCLK edge and measures frame timing.
module tb_spi_prot_tx;

  localparam int unsigned H = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wrt;
  logic [15:0] tx_data;
  logic        len8;
  logic        edg;
  logic        SS_n, SCLK, MOSI, busy, done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  spi_prot_tx #(
    .SCLK_HALF (H)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wrt     (wrt),
    .tx_data (tx_data),
    .len8    (len8),
    .edg     (edg),
    .SS_n    (SS_n),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .busy    (busy),
    .done    (done)
  );

  // Receiver / bus monitor state, written only by the monitor process.
  logic        cur_edg = 1'b1;
  logic        sclk_p = 1'b1, mosi_p = 1'b1, ss_p = 1'b1;
  logic [15:0] cap = '0;
  int low_cnt = 0, low_len = 0, high_cnt = 0, last_gap = 0;
  int rises = 0, falls = 0, nbits = 0, done_cnt = 0, viol = 0, unstable = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (ss_p === 1'b1 && SS_n === 1'b0) begin
        last_gap = high_cnt;
        low_cnt  = 1;
        rises    = 0;
        falls    = 0;
        nbits    = 0;
        cap      = '0;
      end else if (SS_n === 1'b0) begin
        low_cnt++;
      end
      if (ss_p === 1'b0 && SS_n === 1'b1) begin
        low_len  = low_cnt;
        high_cnt = 1;
      end else if (SS_n === 1'b1) begin
        high_cnt++;
      end
      if (SS_n === 1'b0 && SCLK !== sclk_p) begin
        if (SCLK === 1'b1) rises++;
        else falls++;
        if (SCLK === cur_edg) begin
          cap = {cap[14:0], MOSI};
          nbits++;
          if (MOSI !== mosi_p) unstable++;
        end
      end
      if (SS_n === 1'b1 && SCLK === 1'b0) viol++;
      if (done === 1'b1) done_cnt++;
      sclk_p = SCLK;
      mosi_p = MOSI;
      ss_p   = SS_n;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no end of run, required finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Call at #1 after a posedge with busy low; returns #1 after the accepting edge.
  task automatic start_frame(input string tag, input logic [15:0] d, input logic l8,
                             input logic e);
    tx_data = d;
    len8    = l8;
    edg     = e;
    cur_edg = e;
    wrt     = 1'b1;
    @(posedge clk);
    #1;
    wrt = 1'b0;
    check({tag, "_acc_busy"}, 32'(busy), 32'd1);
    check({tag, "_acc_ss"}, 32'(SS_n), 32'd0);
    check({tag, "_acc_msb"}, 32'(MOSI), 32'(l8 ? d[7] : d[15]));
  endtask

  // Leaves the bench at #1 after the edge that raised done.
  task automatic wait_done(input string tag);
    int  n   = 0;
    logic got = 1'b0;
    while (n < 400 && !got) begin
      @(posedge clk);
      #1;
      n++;
      if (done === 1'b1) got = 1'b1;
    end
    check({tag, "_done_seen"}, 32'(got), 32'd1);
  endtask

  task automatic check_frame(input string tag, input logic [15:0] d, input logic l8,
                             input int done0, input int uns0);
    logic [15:0] exp_w;
    int          n;
    exp_w = l8 ? {8'h00, d[7:0]} : d;
    n     = l8 ? 8 : 16;
    check({tag, "_data"}, 32'(cap), 32'(exp_w));
    check({tag, "_nbits"}, nbits, n);
    check({tag, "_ss_low"}, low_len, (2 * n + 2) * int'(H));
    check({tag, "_rises"}, rises, n);
    check({tag, "_falls"}, falls, n);
    check({tag, "_done_cnt"}, done_cnt - done0, 1);
    check({tag, "_stable"}, unstable - uns0, 0);
    check({tag, "_idle"}, {29'd0, SS_n, SCLK, MOSI}, 32'h7);
  endtask

  task automatic run_frame(input string tag, input logic [15:0] d, input logic l8,
                           input logic e);
    int done0 = done_cnt;
    int uns0  = unstable;
    start_frame(tag, d, l8, e);
    wait_done(tag);
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    check({tag, "_done_1cyc"}, 32'(done), 32'd0);
    check_frame(tag, d, l8, done0, uns0);
  endtask

  initial begin
    logic [15:0] d1, d2;
    int          done0, uns0, n;

    rst     = 1'b1;
    wrt     = 1'b0;
    tx_data = '0;
    len8    = 1'b0;
    edg     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: idle after reset
    repeat (20) @(posedge clk);
    #1;
    check("rst_outs", {28'd0, SS_n, SCLK, MOSI, busy}, 32'hE);
    check("rst_no_done", done_cnt, 0);

    // 2, 3: directed frames
    run_frame("t2", 16'hA5C3, 1'b0, 1'b1);
    run_frame("t3", 16'h00B7, 1'b1, 1'b0);

    // 4: wrt while busy ignored, then back-to-back from the done cycle
    d1    = 16'($urandom);
    done0 = done_cnt;
    uns0  = unstable;
    start_frame("t4a", d1, 1'b0, 1'b1);
    repeat (9) @(posedge clk);
    #1;
    tx_data = 16'hFFFF;
    len8    = 1'b1;
    edg     = 1'b0;
    wrt     = 1'b1;
    @(posedge clk);
    #1;
    wrt = 1'b0;
    check("t4_ignored_ss", 32'(SS_n), 32'd0);
    wait_done("t4a");
    check("t4_first_data", 32'(cap), 32'(d1));
    check("t4_first_rises", rises, 16);
    check("t4_first_stable", unstable - uns0, 0);
    d2 = 16'($urandom);
    start_frame("t4b", d2, 1'b0, 1'b0);
    check("t4_first_done", done_cnt - done0, 1);
    done0 = done_cnt;
    uns0  = unstable;
    wait_done("t4b");
    @(posedge clk);
    #1;
    check_frame("t4b", d2, 1'b0, done0, uns0);
    check("t4_gap", last_gap, 1);

    // 5: reset during bit 5 aborts cleanly
    start_frame("t5a", 16'($urandom), 1'b0, 1'b1);
    n = 0;
    while (n < 200 && rises < 5) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("t5_reached_bit5", 32'(rises >= 5), 32'd1);
    done0 = done_cnt;
    rst   = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("t5_abort_outs", {27'd0, SS_n, SCLK, MOSI, busy, done}, 32'h1C);
    repeat (10) @(posedge clk);
    #1;
    check("t5_no_done", done_cnt - done0, 0);
    run_frame("t5b", 16'h1234, 1'b0, 1'($urandom_range(0, 1)));

    // 6: loopback to a match-16'h5A5A trigger (mask 0, edg=1, 16-bit)
    run_frame("t6a", 16'h5A5A, 1'b0, 1'b1);
    check("t6_fire", 32'(cap === 16'h5A5A), 32'd1);
    run_frame("t6b", 16'h5A5B, 1'b0, 1'b1);
    check("t6_nofire", 32'(cap === 16'h5A5A), 32'd0);

    // Randomized frames
    for (int i = 0; i < 6; i++) begin
      run_frame($sformatf("rnd%0d", i), 16'($urandom), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
    end

    check("sclk_low_while_ss_high", viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
